// File: rtl/rr_datapath_arbiter_pkg.sv
// Shared definitions for the round-robin datapath arbiter: state encoding,
// default sizing and the index-width derivation used by the RTL and the bench.
package rr_datapath_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_e;

    localparam int unsigned DEF_N        = 4;
    localparam int unsigned DEF_MAX_HOLD = 8;

    // Width needed to index n items; never narrower than one bit.
    function automatic int unsigned idw_of(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_datapath_arbiter_pick.sv
// Combinational round-robin pick: first set bit of req searching from last+1
// upward with wrap-around.
//   req   : request vector
//   last  : index of the most recent owner (lowest priority)
//   pick  : one-hot winner, zero when nothing requested
//   idx   : index of the winner
//   found : a winner exists
module rr_datapath_arbiter_pick
    import rr_datapath_arbiter_pkg::*;
#(
    parameter int unsigned N   = DEF_N,
    parameter int unsigned IDW = idw_of(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last,
    output logic [N-1:0]   pick,
    output logic [IDW-1:0] idx,
    output logic           found
);

    localparam int unsigned SW = IDW + 1;

    logic [IDW-1:0] start;
    logic [N-1:0]   rot;
    logic [IDW-1:0] off;
    logic [SW-1:0]  sum;

    // Rotate so the search start lands at bit 0, priority-encode, rotate back.
    always_comb begin
        start = (last == IDW'(N - 1)) ? '0 : last + 1'b1;
        rot   = N'({req, req} >> start);
        off   = '0;
        found = |rot;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDW'(i);
            end
        end
        sum  = {1'b0, start} + {1'b0, off};
        idx  = (sum >= SW'(N)) ? IDW'(sum - SW'(N)) : IDW'(sum);
        pick = found ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/rr_datapath_arbiter.sv
// Round-robin owner scheduler for the shared four-lane datapath. Holds a
// grant while the owner keeps requesting, forces rotation after MAX_HOLD
// cycles when someone else waits, and inserts one idle turnaround cycle
// between owners.
//   clk     : clock
//   rst     : synchronous active-low reset
//   req     : per-requester level request
//   gnt     : one-hot grant (zero when no owner)
//   gnt_id  : current owner index, holds last owner while gnt is zero
//   busy    : gnt is non-zero
//   preempt : one-cycle pulse on the turnaround caused by a timeout
module rr_datapath_arbiter
    import rr_datapath_arbiter_pkg::*;
#(
    parameter int unsigned N        = DEF_N,
    parameter int unsigned MAX_HOLD = DEF_MAX_HOLD,
    parameter int unsigned IDW      = idw_of(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           busy,
    output logic           preempt
);

    localparam int unsigned HCW = idw_of(MAX_HOLD);

    arb_state_e     state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic           busy_q, busy_d;
    logic           preempt_q, preempt_d;
    logic [HCW-1:0] hold_q, hold_d;
    logic [IDW-1:0] last_q, last_d;

    logic [N-1:0]   pick_gnt;
    logic [IDW-1:0] pick_idx;
    logic           pick_found;

    rr_datapath_arbiter_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req   (req),
        .last  (last_q),
        .pick  (pick_gnt),
        .idx   (pick_idx),
        .found (pick_found)
    );

    logic at_max;
    logic owner_req;
    logic competitor;

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        busy_d     = busy_q;
        preempt_d  = 1'b0;
        hold_d     = hold_q;
        last_d     = last_q;
        at_max     = (hold_q == HCW'(MAX_HOLD - 1));
        owner_req  = req[gnt_id_q];
        competitor = |(req & ~gnt_q);

        case (state_q)
            IDLE, TURN: begin
                if (pick_found) begin
                    state_d  = GRANT;
                    gnt_d    = pick_gnt;
                    gnt_id_d = pick_idx;
                    busy_d   = 1'b1;
                    hold_d   = '0;
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                end
            end
            GRANT: begin
                // Release wins over timeout, so preempt only fires while the
                // owner is still requesting.
                if (!owner_req || (at_max && competitor)) begin
                    state_d   = TURN;
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    last_d    = gnt_id_q;
                    preempt_d = owner_req;
                end else if (!at_max) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
            hold_q    <= '0;
            last_q    <= IDW'(N - 1);
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            busy_q    <= busy_d;
            preempt_q <= preempt_d;
            hold_q    <= hold_d;
            last_q    <= last_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign busy    = busy_q;
    assign preempt = preempt_q;

endmodule

// File: tb/tb_rr_datapath_arbiter.sv
// Directed bench for rr_datapath_arbiter (N=4, MAX_HOLD=8).
module tb_rr_datapath_arbiter;
    import rr_datapath_arbiter_pkg::*;

    localparam int unsigned N   = DEF_N;
    localparam int unsigned IDW = idw_of(DEF_N);

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           busy;
    logic           preempt;

    int n_cmp = 0;
    int n_bad = 0;

    rr_datapath_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .preempt (preempt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           rst;
        logic [N-1:0]   req;
        logic [N-1:0]   gnt;
        logic [IDW-1:0] id;
        logic           busy;
        logic           pre;
    } vec_t;

    localparam int NV = 27;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic r, input logic [N-1:0] q, input logic [N-1:0] g,
                                input logic [IDW-1:0] i, input logic b, input logic p);
        vec_t v;
        v.rst = r; v.req = q; v.gnt = g; v.id = i; v.busy = b; v.pre = p;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Drive inputs mid-cycle, then sample just after the following rising edge.
    task automatic step(input logic r, input logic [N-1:0] q);
        @(negedge clk);
        rst = r;
        req = q;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [N-1:0] g, input logic [IDW-1:0] i,
                           input logic b, input logic p);
        chk({tag, ".gnt"}, 32'(gnt), 32'(g));
        if (b) chk({tag, ".gnt_id"}, 32'(gnt_id), 32'(i));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".preempt"}, 32'(preempt), 32'(p));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        req = '0;

        // Reset, single requester, release; then reset and round-robin rotation.
        tbl[0]  = mk(0, 4'b0000, 4'b0000, 0, 0, 0);
        tbl[1]  = mk(0, 4'b0000, 4'b0000, 0, 0, 0);
        tbl[2]  = mk(1, 4'b0100, 4'b0100, 2, 1, 0);
        tbl[3]  = mk(1, 4'b0100, 4'b0100, 2, 1, 0);
        tbl[4]  = mk(1, 4'b0000, 4'b0000, 2, 0, 0);
        tbl[5]  = mk(1, 4'b0000, 4'b0000, 2, 0, 0);
        tbl[6]  = mk(1, 4'b0000, 4'b0000, 2, 0, 0);
        tbl[7]  = mk(0, 4'b1111, 4'b0000, 0, 0, 0);
        tbl[8]  = mk(1, 4'b1111, 4'b0001, 0, 1, 0);
        tbl[9]  = mk(1, 4'b1111, 4'b0001, 0, 1, 0);
        tbl[10] = mk(1, 4'b1111, 4'b0001, 0, 1, 0);
        tbl[11] = mk(1, 4'b1110, 4'b0000, 0, 0, 0);
        tbl[12] = mk(1, 4'b1110, 4'b0010, 1, 1, 0);
        tbl[13] = mk(1, 4'b1110, 4'b0010, 1, 1, 0);
        tbl[14] = mk(1, 4'b1110, 4'b0010, 1, 1, 0);
        tbl[15] = mk(1, 4'b1100, 4'b0000, 1, 0, 0);
        tbl[16] = mk(1, 4'b1100, 4'b0100, 2, 1, 0);
        tbl[17] = mk(1, 4'b1100, 4'b0100, 2, 1, 0);
        tbl[18] = mk(1, 4'b1100, 4'b0100, 2, 1, 0);
        tbl[19] = mk(1, 4'b1000, 4'b0000, 2, 0, 0);
        tbl[20] = mk(1, 4'b1000, 4'b1000, 3, 1, 0);
        tbl[21] = mk(1, 4'b1000, 4'b1000, 3, 1, 0);
        tbl[22] = mk(1, 4'b1000, 4'b1000, 3, 1, 0);
        tbl[23] = mk(1, 4'b0001, 4'b0000, 3, 0, 0);
        tbl[24] = mk(1, 4'b0001, 4'b0001, 0, 1, 0);
        tbl[25] = mk(1, 4'b0000, 4'b0000, 0, 0, 0);
        tbl[26] = mk(1, 4'b0000, 4'b0000, 0, 0, 0);

        for (int v = 0; v < NV; v++) begin
            step(tbl[v].rst, tbl[v].req);
            chk_all($sformatf("vec%0d", v), tbl[v].gnt, tbl[v].id, tbl[v].busy, tbl[v].pre);
        end
        // gnt_id holds the last owner while idle.
        chk("idle_hold.gnt_id", 32'(gnt_id), 32'd0);

        // Timeout preemption between requesters 0 and 1.
        step(0, 4'b0000);
        step(0, 4'b0000);
        for (int c = 0; c < 8; c++) begin
            step(1, 4'b0011);
            chk_all($sformatf("to_own0_c%0d", c), 4'b0001, 0, 1, 0);
        end
        step(1, 4'b0011);
        chk_all("to_turn0", 4'b0000, 0, 0, 1);
        for (int c = 0; c < 8; c++) begin
            step(1, 4'b0011);
            chk_all($sformatf("to_own1_c%0d", c), 4'b0010, 1, 1, 0);
        end
        step(1, 4'b0011);
        chk_all("to_turn1", 4'b0000, 1, 0, 1);
        step(1, 4'b0011);
        chk_all("to_back0", 4'b0001, 0, 1, 0);

        // No competitor: grant held, never preempted.
        step(0, 4'b0000);
        for (int c = 0; c < 40; c++) begin
            step(1, 4'b1000);
            chk($sformatf("sat_c%0d.gnt", c), 32'(gnt), 32'b1000);
            chk($sformatf("sat_c%0d.pre", c), 32'(preempt), 32'd0);
        end

        // Owner release coinciding with timeout is a plain release.
        step(0, 4'b0000);
        step(1, 4'b0100);
        chk_all("sim_grant2", 4'b0100, 2, 1, 0);
        for (int c = 0; c < 7; c++) begin
            step(1, 4'b0101);
            chk_all($sformatf("sim_hold_c%0d", c), 4'b0100, 2, 1, 0);
        end
        step(1, 4'b0001);
        chk_all("sim_turn", 4'b0000, 2, 0, 0);
        step(1, 4'b0001);
        chk_all("sim_next0", 4'b0001, 0, 1, 0);

        // Reset in the middle of a grant.
        step(0, 4'b0000);
        step(1, 4'b1000);
        chk_all("mid_own3", 4'b1000, 3, 1, 0);
        step(1, 4'b1000);
        step(0, 4'b1010);
        chk_all("mid_rst", 4'b0000, 0, 0, 0);
        chk("mid_rst.gnt_id", 32'(gnt_id), 32'd0);
        step(1, 4'b1010);
        chk_all("mid_after", 4'b0010, 1, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
